// File: rtl/add_pkg.sv
// Shared definitions for the multi-word sequential adder: word width and FSM state.
package add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/add_seq_32_fa.sv
// 32-bit full adder: the only arithmetic on the sum path of add_seq_32.
module FA_32
  import add_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  logic [WORD_W:0] full_sum;

  // Zero-extend both operands so the top bit of the result is the carry-out.
  always_comb begin
    full_sum = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};
    sum_o    = full_sum[WORD_W-1:0];
    cout_o   = full_sum[WORD_W];
  end

endmodule

// File: rtl/add_seq_32.sv
// Packet-oriented multi-word adder/subtractor. Operands stream in least-significant
// word first; carry ripples between words through carry_q, and each accepted word
// produces one registered result word one cycle later.
module add_seq_32
  import add_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_idx,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              err_pkt
);

  // Word index counter saturates instead of wrapping on very long packets.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Two's-complement overflow: operands share a sign and the result sign differs.
  function automatic logic signed_ovf(input logic signed [WORD_W-1:0] a,
                                      input logic signed [WORD_W-1:0] b,
                                      input logic signed [WORD_W-1:0] s);
    return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
  endfunction

  state_e            state_q, state_d;
  logic              carry_q, carry_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_sum_q, out_sum_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  out_idx_q, out_idx_d;
  logic              out_cout_q, out_cout_d;
  logic              out_ovf_q, out_ovf_d;
  logic              err_q, err_d;

  logic              acc;
  logic              first_eff;
  logic              frame_err;
  logic              mode_w;
  logic [WORD_W-1:0] b_eff;
  logic              cin_w;
  logic [WORD_W-1:0] sum_w;
  logic              cout_w;
  logic [CNT_W-1:0]  word_idx;

  // in_ready depends only on registered out_valid and downstream out_ready.
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: any accepted word lands in IDLE if it closes the packet, else BUSY.
  always_comb begin
    state_d = state_q;
    if (acc) state_d = in_last ? ST_IDLE : ST_BUSY;
  end

  // FSM outputs: whether this word starts a packet, and whether its framing is wrong.
  always_comb begin
    first_eff = (state_q == ST_IDLE) || in_first;
    frame_err = acc && ((state_q == ST_IDLE) ? !in_first : in_first);
  end

  // Per-word operand conditioning: mode and carry-in come fresh on a first word.
  always_comb begin
    mode_w   = first_eff ? in_sub : mode_q;
    b_eff    = mode_w ? ~in_b : in_b;
    cin_w    = first_eff ? mode_w : carry_q;
    word_idx = first_eff ? '0 : idx_q;
  end

  FA_32 u_fa (
    .a_i    (in_a),
    .b_i    (b_eff),
    .cin_i  (cin_w),
    .sum_o  (sum_w),
    .cout_o (cout_w)
  );

  // Next-state for packet context and output stage; outputs hold unless a word is accepted.
  always_comb begin
    carry_d     = carry_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    err_d       = frame_err;
    if (acc) begin
      carry_d     = cout_w;
      mode_d      = mode_w;
      idx_d       = sat_inc(word_idx);
      out_valid_d = 1'b1;
      out_sum_d   = sum_w;
      out_last_d  = in_last;
      out_idx_d   = word_idx;
      out_cout_d  = in_last ? cout_w : 1'b0;
      out_ovf_d   = in_last ? signed_ovf(in_a, b_eff, sum_w) : 1'b0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Packet context and output stage registers; reset discards any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_idx   = out_idx_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign err_pkt   = err_q;

endmodule

// File: tb/tb_add_seq_32.sv
// Directed bench for add_seq_32: a table of word-by-word vectors plus hand-written
// sequences for backpressure, idx saturation and reset mid-packet.
module tb_add_seq_32;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_first;
  logic             in_last;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             out_last;
  logic [CNT_W-1:0] out_idx;
  logic             out_cout;
  logic             out_ovf;
  logic             err_pkt;

  int n_vec = 0;
  int n_bad = 0;

  add_seq_32 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .err_pkt   (err_pkt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        first;
    logic        last;
    logic        sub;
    logic [31:0] sum;
    logic [7:0]  idx;
    logic        cout;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic f, input logic l, input logic s,
                         input logic [31:0] sum, input logic [7:0] idx,
                         input logic cout, input logic ovf, input logic err);
    vec_t v;
    v.name = nm; v.a = a; v.b = b; v.first = f; v.last = l; v.sub = s;
    v.sum = sum; v.idx = idx; v.cout = cout; v.ovf = ovf; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one word, wait (bounded) for acceptance, then sample #1 after the edge.
  task automatic send_word(input logic [31:0] a, input logic [31:0] b,
                           input logic f, input logic l, input logic s);
    int guard;
    in_a = a; in_b = b; in_first = f; in_last = l; in_sub = s;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] out_vec();
    return {19'd0, out_valid, out_sum, out_last, out_idx, out_cout, out_ovf, err_pkt};
  endfunction

  function automatic logic [63:0] exp_vec(input logic [31:0] sum, input logic lst,
                                          input logic [7:0] idx, input logic cout,
                                          input logic ovf, input logic err);
    return {19'd0, 1'b1, sum, lst, idx, cout, ovf, err};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {19'd0, out_valid, out_sum, out_last, out_idx, out_cout, out_ovf, err_pkt},
        64'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    //       name          a             b             f     l     s     sum           idx  co    ov    err
    add_vec("single_add",  32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'h00000000, 8'd0, 1'b1, 1'b0, 1'b0);
    add_vec("two_add_w0",  32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h00000000, 8'd0, 1'b0, 1'b0, 1'b0);
    add_vec("two_add_w1",  32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h80000000, 8'd1, 1'b0, 1'b1, 1'b0);
    add_vec("sub_5_7",     32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 8'd0, 1'b0, 1'b0, 1'b0);
    add_vec("sub_7_5",     32'h00000007, 32'h00000005, 1'b1, 1'b1, 1'b1, 32'h00000002, 8'd0, 1'b1, 1'b0, 1'b0);
    add_vec("frame_w0",    32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b0, 32'h00000003, 8'd0, 1'b0, 1'b0, 1'b0);
    add_vec("frame_w1",    32'h00000010, 32'h00000020, 1'b1, 1'b0, 1'b0, 32'h00000030, 8'd0, 1'b0, 1'b0, 1'b1);
    add_vec("frame_w2",    32'h00000004, 32'h00000005, 1'b0, 1'b1, 1'b0, 32'h00000009, 8'd1, 1'b0, 1'b0, 1'b0);
    add_vec("sub2_w0",     32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 8'd0, 1'b0, 1'b0, 1'b0);
    add_vec("sub2_w1",     32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00000000, 8'd1, 1'b1, 1'b0, 1'b0);
    add_vec("idle_nofirst",32'h00000003, 32'h00000004, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 8'd0, 1'b0, 1'b0, 1'b1);
    add_vec("neg_ovf_add", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 8'd0, 1'b1, 1'b1, 1'b0);
    add_vec("neg_ovf_sub", 32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 8'd0, 1'b1, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      send_word(vecs[i].a, vecs[i].b, vecs[i].first, vecs[i].last, vecs[i].sub);
      chk(vecs[i].name, out_vec(),
          exp_vec(vecs[i].sum, vecs[i].last, vecs[i].idx, vecs[i].cout, vecs[i].ovf, vecs[i].err));
    end

    // Backpressure: 4-word stream, downstream stalled for 3 cycles after the first result.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_word(32'd1, 32'h10, 1'b1, 1'b0, 1'b0);
    chk("bp_w0", out_vec(), exp_vec(32'h11, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    in_a = 32'd2; in_b = 32'h10; in_first = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_stall", {30'd0, in_ready, out_valid, out_sum}, {30'd0, 1'b0, 1'b1, 32'h11});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk("bp_drain", out_vec(),
          exp_vec(32'h10 + 32'(k + 1), (k == 3), 8'(k), 1'b0, 1'b0, 1'b0));
      in_a = 32'(k + 2); in_last = (k + 1 == 3);
      if (k == 3) in_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Index counter saturation on a 300-word packet.
    for (int i = 0; i < 300; i++) begin
      send_word(32'd0, 32'd0, (i == 0), (i == 299), 1'b0);
      if (i == 254 || i == 255 || i == 299)
        chk("idx_sat", {55'd0, out_last, out_idx}, {55'd0, (i == 299), 8'((i > 255) ? 255 : i)});
    end

    // Reset after word 1 of a 3-word packet.
    send_word(32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    chk("rst_w0", out_vec(), exp_vec(32'd2, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_clear", {63'd0, out_valid}, 64'd0);
    send_word(32'd5, 32'd7, 1'b0, 1'b1, 1'b1);
    chk("rst_after", out_vec(), exp_vec(32'hFFFFFFFE, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1));
    @(posedge clk); #1;
    chk("err_one_cycle", {62'd0, err_pkt, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/add_seq_32.md
ADD_SEQ_32 -- requirements
Module: add_seq_32

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the per-packet word index counter.
REQ-002 SHALL have one clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_a  input  32  operand A word, least-significant word first.
REQ-008 in_b  input  32  operand B word.
REQ-009 in_first  input  1  word is the first word of a packet.
REQ-010 in_last  input  1  word is the last word of a packet; first and last may both be set.
REQ-011 in_sub  input  1  packet mode: 0 = A+B, 1 = A-B; sampled on the first word only.
REQ-012 out_valid  output  1  result word valid.
REQ-013 out_ready  input  1  downstream accepts the result word.
REQ-014 out_sum  output  32  result word.
REQ-015 out_last  output  1  result word is the last word of the packet.
REQ-016 out_idx  output  CNT_W  word index within the packet, starting at 0.
REQ-017 out_cout  output  1  carry out of the last word; valid only when out_last=1, otherwise 0.
REQ-018 out_ovf  output  1  signed overflow of the full packet; valid only when out_last=1, otherwise 0.
REQ-019 err_pkt  output  1  one-cycle pulse on a framing error.

Function
REQ-020 A word SHALL transfer when in_valid && in_ready, and a result SHALL transfer when out_valid && out_ready.
REQ-021 in_ready SHALL equal !out_valid || out_ready, so back-to-back words run at full throughput with no combinational path from in_valid to in_ready.
REQ-022 Per accepted word: b_eff = mode ? ~in_b : in_b, and cin = (first word) ? mode : carry_q.
  - mode is in_sub on the first word and the latched mode_q otherwise.
REQ-023 Each accepted word SHALL register {sum, last, idx, cout, ovf} into the output stage on the same edge, with latency 1 cycle from acceptance to out_valid.
REQ-024 carry_q SHALL be loaded with the 32-bit adder carry-out on every accepted word.
REQ-025 ovf SHALL be (in_a[31] == b_eff[31]) && (sum[31] != in_a[31]), computed on the last word only.
REQ-026 The FSM SHALL have two states: IDLE (expecting a first word) and BUSY (mid-packet).
  - IDLE -> BUSY on accepting a word with in_last=0.
  - BUSY -> IDLE on accepting a word with in_last=1.
  - A word with first=last=1 in IDLE SHALL stay in IDLE.
REQ-027 In BUSY, an accepted word with in_first=1 SHALL abandon the current packet, restart as a first word (idx=0, cin=in_sub), and pulse err_pkt.
REQ-028 In IDLE, an accepted word with in_first=0 SHALL be treated as a first word and pulse err_pkt.
REQ-029 The idx counter SHALL reset to 0 on each first word and increment per accepted word, saturating at 2^CNT_W-1.
REQ-030 While out_valid && !out_ready, all output registers SHALL hold stable and no word SHALL be accepted.
REQ-031 Simultaneous output drain and input accept SHALL replace the output register without a bubble.

Reset
REQ-032 On rst: state=IDLE, out_valid=0, carry_q=0, mode_q=0, idx=0, err_pkt=0, and out_sum, out_last, out_idx, out_cout, out_ovf all 0.
REQ-033 rst asserted mid-packet SHALL discard the partial packet and any pending output word; the next accepted word SHALL be handled under REQ-028.

Structure
REQ-034 A shared package add_pkg SHALL hold the FSM state enum and the constant WORD_W=32.
REQ-035 The block SHALL instantiate exactly one FA_32 sub-module as its datapath adder; there SHALL be no other arithmetic on the sum path.

Verification
REQ-036 Single word: A=0xFFFFFFFF, B=1, first=last=1, add -> sum=0, cout=1, ovf=0, idx=0.
REQ-037 Two words, add: (A0=0xFFFFFFFF, B0=1) then (A1=0x7FFFFFFF, B1=0) -> sum 0x00000000 then 0x80000000, cout=0, ovf=1, idx 0,1.
REQ-038 Single-word subtract: A=5, B=7 -> sum=0xFFFFFFFE, cout=0; A=7, B=5 -> sum=2, cout=1.
REQ-039 Backpressure: out_ready held 0 for 3 cycles with a 4-word stream -> in_ready=0, out_sum stable, no word lost; all 4 words then drain back-to-back.
REQ-040 Framing: in_first asserted on word 2 of a 3-word packet -> err_pkt pulses one cycle and out_idx returns to 0 on that word.
REQ-041 Reset mid-packet: assert rst after word 1 of 3 -> out_valid=0 next cycle; a following word with first=0 raises err_pkt and uses cin=in_sub.
